// File: rtl/mips_defs.sv
// Shared MIPS-subset definitions: opcodes, funct codes, ALU ops, word type.
// No ports; imported by cpu, register_file, rom and mips_sopc.
package mips_defs;

  typedef logic [31:0] word_t;

  localparam logic [5:0] OP_SPECIAL = 6'h00;
  localparam logic [5:0] OP_J       = 6'h02;
  localparam logic [5:0] OP_BEQ     = 6'h04;
  localparam logic [5:0] OP_BNE     = 6'h05;
  localparam logic [5:0] OP_ADDI    = 6'h08;
  localparam logic [5:0] OP_ADDIU   = 6'h09;
  localparam logic [5:0] OP_SLTI    = 6'h0A;
  localparam logic [5:0] OP_SLTIU   = 6'h0B;
  localparam logic [5:0] OP_ANDI    = 6'h0C;
  localparam logic [5:0] OP_ORI     = 6'h0D;
  localparam logic [5:0] OP_XORI    = 6'h0E;
  localparam logic [5:0] OP_LUI     = 6'h0F;

  localparam logic [5:0] F_SLL  = 6'h00;
  localparam logic [5:0] F_SRL  = 6'h02;
  localparam logic [5:0] F_SRA  = 6'h03;
  localparam logic [5:0] F_SLLV = 6'h04;
  localparam logic [5:0] F_SRLV = 6'h06;
  localparam logic [5:0] F_SRAV = 6'h07;
  localparam logic [5:0] F_JR   = 6'h08;
  localparam logic [5:0] F_MFHI = 6'h10;
  localparam logic [5:0] F_MTHI = 6'h11;
  localparam logic [5:0] F_MFLO = 6'h12;
  localparam logic [5:0] F_MTLO = 6'h13;
  localparam logic [5:0] F_ADD  = 6'h20;
  localparam logic [5:0] F_ADDU = 6'h21;
  localparam logic [5:0] F_SUB  = 6'h22;
  localparam logic [5:0] F_SUBU = 6'h23;
  localparam logic [5:0] F_AND  = 6'h24;
  localparam logic [5:0] F_OR   = 6'h25;
  localparam logic [5:0] F_XOR  = 6'h26;
  localparam logic [5:0] F_NOR  = 6'h27;
  localparam logic [5:0] F_SLT  = 6'h2A;
  localparam logic [5:0] F_SLTU = 6'h2B;

  typedef enum logic [3:0] {
    ALU_NOP,
    ALU_ADD,
    ALU_SUB,
    ALU_AND,
    ALU_OR,
    ALU_XOR,
    ALU_NOR,
    ALU_SLT,
    ALU_SLTU,
    ALU_SLL,
    ALU_SRL,
    ALU_SRA,
    ALU_LUI,
    ALU_MFHI,
    ALU_MFLO
  } alu_op_e;

endpackage

// File: rtl/cpu.sv
// Single-cycle MIPS-subset core: decode, ALU, pc, hi/lo, register file.
// Ports: clk_i, rst_ni, iaddr_o (fetch address), instr_i (fetched word).
module cpu
  import mips_defs::*;
#(
  parameter word_t RESET_PC = 32'h0000_0000
) (
  input  logic  clk_i,
  input  logic  rst_ni,
  output word_t iaddr_o,
  input  word_t instr_i
);

  word_t pc, pc_d;
  word_t hi, hi_d;
  word_t lo, lo_d;

  logic [5:0]  op, funct;
  logic [4:0]  rs, rt, rd, shamt;
  logic [15:0] imm;

  assign op    = instr_i[31:26];
  assign rs    = instr_i[25:21];
  assign rt    = instr_i[20:16];
  assign rd    = instr_i[15:11];
  assign shamt = instr_i[10:6];
  assign funct = instr_i[5:0];
  assign imm   = instr_i[15:0];

  word_t rs_val, rt_val;
  word_t wb_val;
  logic  wb_we;
  logic [4:0] wb_addr;

  register_file register (
    .clk_i    (clk_i),
    .rst_ni   (rst_ni),
    .raddr1_i (rs),
    .raddr2_i (rt),
    .rdata1_o (rs_val),
    .rdata2_o (rt_val),
    .we_i     (wb_we),
    .waddr_i  (wb_addr),
    .wdata_i  (wb_val)
  );

  alu_op_e alu_op;
  logic    use_imm, var_sh;
  logic    hi_we, lo_we;
  logic    br_take, jmp, jr;
  word_t   imm_ext;

  always_comb begin
    alu_op  = ALU_NOP;
    use_imm = 1'b0;
    var_sh  = 1'b0;
    imm_ext = {{16{imm[15]}}, imm};
    wb_we   = 1'b0;
    wb_addr = rd;
    hi_we   = 1'b0;
    lo_we   = 1'b0;
    br_take = 1'b0;
    jmp     = 1'b0;
    jr      = 1'b0;
    case (op)
      OP_SPECIAL: begin
        wb_we = 1'b1;
        case (funct)
          F_SLL:  alu_op = ALU_SLL;
          F_SRL:  alu_op = ALU_SRL;
          F_SRA:  alu_op = ALU_SRA;
          F_SLLV: begin alu_op = ALU_SLL; var_sh = 1'b1; end
          F_SRLV: begin alu_op = ALU_SRL; var_sh = 1'b1; end
          F_SRAV: begin alu_op = ALU_SRA; var_sh = 1'b1; end
          F_ADD,
          F_ADDU: alu_op = ALU_ADD;
          F_SUB,
          F_SUBU: alu_op = ALU_SUB;
          F_AND:  alu_op = ALU_AND;
          F_OR:   alu_op = ALU_OR;
          F_XOR:  alu_op = ALU_XOR;
          F_NOR:  alu_op = ALU_NOR;
          F_SLT:  alu_op = ALU_SLT;
          F_SLTU: alu_op = ALU_SLTU;
          F_MFHI: alu_op = ALU_MFHI;
          F_MFLO: alu_op = ALU_MFLO;
          F_MTHI: begin wb_we = 1'b0; hi_we = 1'b1; end
          F_MTLO: begin wb_we = 1'b0; lo_we = 1'b1; end
          F_JR:   begin wb_we = 1'b0; jr = 1'b1; end
          default: wb_we = 1'b0;
        endcase
      end
      OP_J:   jmp = 1'b1;
      OP_BEQ: br_take = (rs_val == rt_val);
      OP_BNE: br_take = (rs_val != rt_val);
      OP_ADDI,
      OP_ADDIU: begin
        alu_op = ALU_ADD; use_imm = 1'b1;
        wb_we = 1'b1; wb_addr = rt;
      end
      OP_SLTI: begin
        alu_op = ALU_SLT; use_imm = 1'b1;
        wb_we = 1'b1; wb_addr = rt;
      end
      OP_SLTIU: begin
        alu_op = ALU_SLTU; use_imm = 1'b1;
        wb_we = 1'b1; wb_addr = rt;
      end
      OP_ANDI: begin
        alu_op = ALU_AND; use_imm = 1'b1;
        imm_ext = {16'h0, imm};
        wb_we = 1'b1; wb_addr = rt;
      end
      OP_ORI: begin
        alu_op = ALU_OR; use_imm = 1'b1;
        imm_ext = {16'h0, imm};
        wb_we = 1'b1; wb_addr = rt;
      end
      OP_XORI: begin
        alu_op = ALU_XOR; use_imm = 1'b1;
        imm_ext = {16'h0, imm};
        wb_we = 1'b1; wb_addr = rt;
      end
      OP_LUI: begin
        alu_op = ALU_LUI;
        wb_we = 1'b1; wb_addr = rt;
      end
      default: ;
    endcase
  end

  word_t      opb;
  logic [4:0] sa;

  assign opb = use_imm ? imm_ext : rt_val;
  assign sa  = var_sh ? rs_val[4:0] : shamt;

  always_comb begin
    wb_val = '0;
    case (alu_op)
      ALU_ADD:  wb_val = rs_val + opb;
      ALU_SUB:  wb_val = rs_val - opb;
      ALU_AND:  wb_val = rs_val & opb;
      ALU_OR:   wb_val = rs_val | opb;
      ALU_XOR:  wb_val = rs_val ^ opb;
      ALU_NOR:  wb_val = ~(rs_val | opb);
      ALU_SLT:  wb_val = {31'h0, $signed(rs_val) < $signed(opb)};
      ALU_SLTU: wb_val = {31'h0, rs_val < opb};
      ALU_SLL:  wb_val = rt_val << sa;
      ALU_SRL:  wb_val = rt_val >> sa;
      ALU_SRA:  wb_val = $signed(rt_val) >>> sa;
      ALU_LUI:  wb_val = {imm, 16'h0};
      ALU_MFHI: wb_val = hi;
      ALU_MFLO: wb_val = lo;
      default:  wb_val = '0;
    endcase
  end

  word_t pc4;

  assign pc4 = pc + 32'd4;

  always_comb begin
    pc_d = pc4;
    hi_d = hi_we ? rs_val : hi;
    lo_d = lo_we ? rs_val : lo;
    if (br_take)  pc_d = pc4 + {{14{imm[15]}}, imm, 2'b00};
    else if (jmp) pc_d = {pc4[31:28], instr_i[25:0], 2'b00};
    else if (jr)  pc_d = rs_val;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      pc <= RESET_PC;
      hi <= '0;
      lo <= '0;
    end else begin
      pc <= pc_d;
      hi <= hi_d;
      lo <= lo_d;
    end
  end

  assign iaddr_o = pc;

endmodule

// File: rtl/register_file.sv
// 32x32 register file: two combinational reads, one clocked write, $0 = 0.
// Ports: clk_i, rst_ni, raddr1_i/rdata1_o, raddr2_i/rdata2_o, we_i, waddr_i, wdata_i.
module register_file
  import mips_defs::*;
(
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic [4:0] raddr1_i,
  input  logic [4:0] raddr2_i,
  output word_t      rdata1_o,
  output word_t      rdata2_o,
  input  logic       we_i,
  input  logic [4:0] waddr_i,
  input  word_t      wdata_i
);

  word_t storage [0:31];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < 32; i++) storage[i] <= '0;
    end else if (we_i && (waddr_i != 5'd0)) begin
      storage[waddr_i] <= wdata_i;
    end
  end

  assign rdata1_o = storage[raddr1_i];
  assign rdata2_o = storage[raddr2_i];

endmodule

// File: rtl/rom.sv
// Instruction ROM with combinational word read; out-of-range reads give 0.
// Ports: clk_i, we_i/waddr_i/wdata_i (load port), addr_i (byte addr), data_o.
module rom
  import mips_defs::*;
#(
  parameter int DEPTH = 1024,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk_i,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  word_t         wdata_i,
  input  word_t         addr_i,
  output word_t         data_o
);

  word_t       storage [0:DEPTH-1];
  logic [29:0] widx;
  logic        unused_lsb;

  // Contents are never reset; preloaded from outside or via the load port.
  always_ff @(posedge clk_i) begin
    if (we_i) storage[waddr_i] <= wdata_i;
  end

  assign widx       = addr_i[31:2];
  assign unused_lsb = ^addr_i[1:0];
  assign data_o     = (widx < 30'(DEPTH)) ? storage[widx[AW-1:0]] : '0;

endmodule

// File: rtl/mips_sopc.sv
// Minimal MIPS SoC top: single-cycle cpu fetching from an instruction rom.
// Ports: clock (rising edge), reset (async, active-low).
module mips_sopc
  import mips_defs::*;
#(
  parameter int    ROM_DEPTH = 1024,
  parameter word_t RESET_PC  = 32'h0000_0000
) (
  input logic clock,
  input logic reset
);

  localparam int AW = $clog2(ROM_DEPTH);

  word_t iaddr, instr;

  cpu #(
    .RESET_PC (RESET_PC)
  ) cpu (
    .clk_i   (clock),
    .rst_ni  (reset),
    .iaddr_o (iaddr),
    .instr_i (instr)
  );

  // Load port tied off: the program is preloaded into rom.storage.
  rom #(
    .DEPTH (ROM_DEPTH)
  ) rom (
    .clk_i   (clock),
    .we_i    (1'b0),
    .waddr_i ({AW{1'b0}}),
    .wdata_i ('0),
    .addr_i  (iaddr),
    .data_o  (instr)
  );

endmodule

// File: tb/tb_mips_sopc.sv
// Directed bench for mips_sopc: preloads a program, checks probes per cycle.
// Drives clock/reset only; observes pc, hi, lo and register storage.
module tb_mips_sopc;

  logic clock;
  logic reset;

  int n_vec;
  int n_bad;

  mips_sopc dut (
    .clock (clock),
    .reset (reset)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  logic [31:0] prog [17];

  initial begin
    n_vec = 0;
    n_bad = 0;
    reset = 1'b0;
    prog = '{
      32'h34011100,  // 00 ori  $1,$0,0x1100
      32'h3C020101,  // 04 lui  $2,0x0101
      32'h00221825,  // 08 or   $3,$1,$2
      32'h2404FFFF,  // 0C addiu $4,$0,-1
      32'h10000001,  // 10 beq  $0,$0,+1
      32'h3408DEAD,  // 14 ori  $8 (skipped)
      32'h34001234,  // 18 ori  $0,$0,0x1234
      32'h00042A02,  // 1C srl  $5,$4,8
      32'h00043303,  // 20 sra  $6,$4,12
      32'h00200011,  // 24 mthi $1
      32'h00400013,  // 28 mtlo $2
      32'h00003810,  // 2C mfhi $7
      32'h14210005,  // 30 bne  $1,$1,+5
      32'hFC000000,  // 34 undefined
      32'h00814823,  // 38 subu $9,$4,$1
      32'h0081502A,  // 3C slt  $10,$4,$1
      32'h08000000   // 40 j    0
    };
    for (int i = 0; i < 1024; i++) dut.rom.storage[i] = 32'h0;
    for (int i = 0; i < 17; i++) dut.rom.storage[i] = prog[i];

    repeat (3) @(posedge clock);
    #1;
    chk("rst_pc", dut.cpu.pc, 32'h0);
    chk("rst_hi", dut.cpu.hi, 32'h0);
    chk("rst_lo", dut.cpu.lo, 32'h0);
    for (int r = 0; r < 32; r++)
      chk($sformatf("rst_r%0d", r), dut.cpu.register.storage[r], 32'h0);

    @(negedge clock);
    reset = 1'b1;

    step();
    chk("ori_pc", dut.cpu.pc, 32'h4);
    chk("ori_r1", dut.cpu.register.storage[1], 32'h00001100);
    step();
    chk("lui_pc", dut.cpu.pc, 32'h8);
    chk("lui_r2", dut.cpu.register.storage[2], 32'h01010000);
    step();
    chk("or_r3", dut.cpu.register.storage[3], 32'h01011100);
    step();
    chk("addiu_r4", dut.cpu.register.storage[4], 32'hFFFFFFFF);
    chk("addiu_pc", dut.cpu.pc, 32'h10);
    step();
    chk("beq_pc", dut.cpu.pc, 32'h18);
    step();
    chk("r0_zero", dut.cpu.register.storage[0], 32'h0);
    chk("skip_r8", dut.cpu.register.storage[8], 32'h0);
    chk("r0_pc", dut.cpu.pc, 32'h1C);
    step();
    chk("srl_r5", dut.cpu.register.storage[5], 32'h00FFFFFF);
    step();
    chk("sra_r6", dut.cpu.register.storage[6], 32'hFFFFFFFF);
    step();
    chk("mthi", dut.cpu.hi, 32'h00001100);
    step();
    chk("mtlo", dut.cpu.lo, 32'h01010000);
    chk("mtlo_hi", dut.cpu.hi, 32'h00001100);
    step();
    chk("mfhi_r7", dut.cpu.register.storage[7], 32'h00001100);
    step();
    chk("bne_pc", dut.cpu.pc, 32'h34);
    step();
    chk("undef_pc", dut.cpu.pc, 32'h38);
    chk("undef_r7", dut.cpu.register.storage[7], 32'h00001100);
    chk("undef_r3", dut.cpu.register.storage[3], 32'h01011100);
    chk("undef_r9", dut.cpu.register.storage[9], 32'h0);
    chk("undef_lo", dut.cpu.lo, 32'h01010000);
    step();
    chk("subu_r9", dut.cpu.register.storage[9], 32'hFFFFEEFF);
    step();
    chk("slt_r10", dut.cpu.register.storage[10], 32'h00000001);
    chk("slt_pc", dut.cpu.pc, 32'h40);
    step();
    chk("j_pc", dut.cpu.pc, 32'h0);
    step();
    chk("rerun_pc", dut.cpu.pc, 32'h4);

    @(posedge clock);
    #3;
    reset = 1'b0;
    #1;
    chk("async_pc", dut.cpu.pc, 32'h0);
    chk("async_r1", dut.cpu.register.storage[1], 32'h0);
    chk("async_r4", dut.cpu.register.storage[4], 32'h0);
    chk("async_hi", dut.cpu.hi, 32'h0);
    chk("async_lo", dut.cpu.lo, 32'h0);
    step();
    chk("hold_pc", dut.cpu.pc, 32'h0);
    @(negedge clock);
    reset = 1'b1;
    step();
    chk("restart_pc", dut.cpu.pc, 32'h4);
    chk("restart_r1", dut.cpu.register.storage[1], 32'h00001100);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/mips_sopc.md
Name: mips_sopc

Overview:
- Minimal MIPS system-on-chip: one 32-bit MIPS-subset CPU core plus an instruction ROM.
- Top level of the simulation hierarchy; the bench drives only clock and reset.
- Program is preloaded into the ROM by the bench; results are observed through fixed hierarchical probe points.
- CPU executes one instruction per clock (single-cycle): fetch, decode, execute and writeback complete in one cycle.

Parameters:
- ROM_DEPTH, 1024, number of 32-bit instruction words in the ROM.
- RESET_PC, 32'h0000_0000, PC value after reset.

Ports:
- clock  input  1  system clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-low reset (0 = in reset); applies to all state.

Behaviour:
- Hierarchy (fixed, used by bench probes):
  - instance cpu, containing register-file instance register with array storage[0:31] of 32 bits;
  - cpu.pc (32-bit), cpu.hi, cpu.lo;
  - instance rom with array storage[0:ROM_DEPTH-1] of 32 bits, loadable via $readmemh, no reset of contents.
- Reset (reset==0, asynchronous): pc=RESET_PC; storage[0..31]=0; hi=lo=0. Held while low. First fetch uses RESET_PC on the first rising edge after release.
- Fetch: combinational ROM read; word index pc[log2(ROM_DEPTH)+1:2]. Index >= ROM_DEPTH returns 0 (nop).
- PC: pc += 4 each cycle unless a branch or jump is taken. No delay slots: the branch/jump target is the next instruction executed.
- Register file:
  - two combinational read ports, one write port on the rising edge;
  - writes to $0 ignored; storage[0] is always 0.
- Supported instructions; all others execute as nop (no state change except pc+4):
  - R-type: addu, subu, and, or, xor, nor, slt (signed), sltu, sll, srl, sra (shamt), sllv, srlv, srav (rs[4:0]), mfhi, mflo, mthi, mtlo, jr.
  - I-type: addiu, slti, sltiu (sign-extended imm), andi, ori, xori (zero-extended imm), lui (imm<<16), beq, bne.
  - J-type: j.
- Arithmetic: 32-bit, wrap-around, no overflow traps. add/addi/sub are decoded as addu/addiu/subu.
- Branch target = pc+4 + (signext(imm)<<2).
- j target = {pc+4[31:28], index, 2'b00}.
- jr target = rs.
- mthi/mtlo write hi/lo on the clock edge. mfhi/mflo write rd from the current hi/lo.

Decomposition:
- Shared package mips_defs:
  - opcode constants (SPECIAL=6'h00, J, BEQ, BNE, ADDIU, SLTI, SLTIU, ANDI, ORI, XORI, LUI);
  - funct constants;
  - ALU-op enum typedef;
  - 32-bit word typedef.
- Sub-modules: cpu (decode/ALU/pc/hi-lo), register_file (instance name register), rom. register_file is the natural standalone unit.

Test Plan:
- Reset: hold reset=0 for 3 cycles with a program loaded -> pc=0, all storage=0, hi=lo=0. Deassert -> pc steps 0,4,8,...
- Immediates:
  - 0x34011100 (ori $1,$0,0x1100) -> $1=0x00001100 after 1 cycle;
  - 0x3C020101 (lui $2,0x0101) -> $2=0x01010000;
  - 0x00221825 (or $3,$1,$2) -> $3=0x01011100;
  - 0x2404FFFF (addiu $4,$0,-1) -> $4=0xFFFFFFFF.
- $0 and shifts:
  - 0x34001234 (ori $0,$0,0x1234) -> storage[0] stays 0;
  - 0x00042A02 (srl $5,$4,8) -> $5=0x00FFFFFF;
  - 0x000433 03 (sra $6,$4,12) -> $6=0xFFFFFFFF.
- Hi/lo:
  - mthi $1 then mtlo $2 -> hi=0x00001100, lo=0x01010000;
  - mfhi $7 -> $7=0x00001100.
- Control flow:
  - 0x10000001 (beq $0,$0,+1) at pc 0x10 -> next pc=0x18, instruction at 0x14 not executed;
  - bne equal -> pc+4;
  - 0x08000000 (j 0) -> pc=0.
- Mid-run reset: pull reset low between edges -> pc and registers clear immediately (asynchronously); execution restarts at 0 after release. An undefined opcode (0xFC000000) leaves all registers unchanged.
